// File: rtl/calc_pkg.sv
// Shared op codes, FSM states and key-to-op mapping for the calculator front end.
// Pure declarations: no latency, no backpressure.
package calc_pkg;

    localparam logic [1:0] OP_DIV = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VALID    = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // Only meaningful for a one-hot press vector; KEY0..KEY3 map to DIV..ADD.
    function automatic logic [1:0] key_to_op(input logic [3:0] press);
        logic [1:0] op;
        op = OP_DIV;
        if (press[1]) op = OP_MUL;
        if (press[2]) op = OP_SUB;
        if (press[3]) op = OP_ADD;
        return op;
    endfunction

endpackage

// File: rtl/key_op_capture_if.sv
// Operation request bus toward the arithmetic stage: op code plus two operands.
// Valid/ready: master holds op_valid and payload stable until op_ready is seen.
interface key_op_capture_if #(parameter int W = 8);

    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;

    modport master (output op_valid, output op, output opa, output opb, input op_ready);
    modport slave  (input op_valid, input op, input opa, input opb, output op_ready);

endinterface

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low key into an active-high level.
// Latency 2 + DB_CYCLES clocks from a stable raw edge; no backpressure.
module key_debounce #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic clr,
    input  logic raw_n,
    output logic level
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic [DB_W-1:0] cnt;

    // Synchroniser idles at 1 so a cleared key reads as released.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else if (clr) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (~sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_op_capture.sv
// Turns one clean KEY press into a single op request with operands snapshotted from SW.
// Request appears 1 clock after the debounced press; held with frozen payload until op_ready.
module key_op_capture
    import calc_pkg::*;
#(
    parameter int W         = 8,
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    input  logic [3:0]    key_n,
    input  logic          clr,
    input  logic [W-1:0]  sw_a,
    input  logic [W-1:0]  sw_b,
    key_op_capture_if.master bus,
    output logic [3:0]    key_db,
    output logic          err_multi
);

    logic [3:0]   key_db_q;
    logic [3:0]   press;
    state_t       state, state_d;
    logic         capture;
    logic         op_valid_q, op_valid_d;
    logic         err_d;
    logic [1:0]   op_q;
    logic [W-1:0] opa_q, opb_q;

    for (genvar i = 0; i < 4; i++) begin : g_db
        key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db (
            .CLOCK_50 (CLOCK_50),
            .rst_n    (rst_n),
            .clr      (clr),
            .raw_n    (key_n[i]),
            .level    (key_db[i])
        );
    end

    assign press = key_db & ~key_db_q;

    always_comb begin
        state_d    = state;
        capture    = 1'b0;
        err_d      = 1'b0;
        op_valid_d = op_valid_q;
        case (state)
            ST_IDLE: begin
                if (|press) begin
                    if ($onehot(press)) begin
                        capture    = 1'b1;
                        op_valid_d = 1'b1;
                        state_d    = ST_VALID;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_REL;
                    end
                end
            end
            ST_VALID: begin
                if (bus.op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (key_db == 4'b0000) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_db_q   <= '0;
            op_valid_q <= 1'b0;
            err_multi  <= 1'b0;
            op_q       <= OP_DIV;
            opa_q      <= '0;
            opb_q      <= '0;
        end else if (clr) begin
            key_db_q   <= '0;
            op_valid_q <= 1'b0;
            err_multi  <= 1'b0;
            op_q       <= OP_DIV;
            opa_q      <= '0;
            opb_q      <= '0;
        end else begin
            key_db_q   <= key_db;
            op_valid_q <= op_valid_d;
            err_multi  <= err_d;
            // Payload only moves on capture, so it survives acceptance.
            if (capture) begin
                op_q  <= key_to_op(press);
                opa_q <= sw_a;
                opb_q <= sw_b;
            end
        end
    end

    assign bus.op_valid = op_valid_q;
    assign bus.op       = op_q;
    assign bus.opa      = opa_q;
    assign bus.opb      = opb_q;

endmodule
